audio_dac_tx: RTL

AUDIO_DAC_TX -- requirements
Module: audio_dac_tx

---
 rtl/audio_dac_pkg.sv | 26 ++
 rtl/dac_half_tick.sv | 35 +++
 rtl/audio_dac_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/audio_dac_pkg.sv
// audio_dac_pkg
// Shared definitions for the Pmod DA2 transmitter slice.
//    dac_state_t : transmitter state encoding (IDLE, SETUP, SHIFT, GAP)
//    FRAME_BITS  : bits per serial frame sent to each DAC
//    PD_NORMAL   : DAC121S101 power-down field for normal operation
//    GAP_HALVES  : SCLK half-periods that SYNC is held high between frames
//    make_frame  : builds the 16-bit frame word from a 12-bit code
package audio_dac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_GAP
   } dac_state_t;

   localparam int         FRAME_BITS = 16;
   localparam logic [1:0] PD_NORMAL  = 2'b00;
   localparam int         GAP_HALVES = 2;

   // Frame layout, MSB first: two don't-care bits, power-down mode, code.
   function automatic logic [FRAME_BITS-1:0] make_frame(input logic [11:0] code);
      return {2'b00, PD_NORMAL, code};
   endfunction

endpackage

// File: rtl/dac_half_tick.sv
// dac_half_tick
// Half-period timebase for the DAC serial clock.
//    clk   : system clock
//    reset : synchronous, active-high reset
//    run   : counter advances while high, sits at 0 while low
//    tick  : one-cycle pulse on the last cycle of every half-period
module dac_half_tick #(
   parameter int HALF_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tick
);

   localparam logic [7:0] LAST = 8'(HALF_DIV - 1);

   logic [7:0] count;

   // Holding the count at zero while idle means the first half-period after
   // leaving IDLE is always a full HALF_DIV cycles long; when frames run
   // back to back the wrap on the final GAP tick provides the same restart.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (!run || count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 8'd1;
      end
   end

   assign tick = run && (count == LAST);

endmodule

// File: rtl/audio_dac_tx.sv
// audio_dac_tx
// Serialises 12-bit sample pairs to a Digilent Pmod DA2 (two DAC121S101).
//    clk            : 100 MHz system clock
//    reset          : synchronous, active-high reset
//    sample_valid   : a sample pair is offered this cycle
//    sample_a/b     : unsigned 12-bit codes for DAC A and DAC B
//    sample_ready   : holding register empty, a valid pair will be taken
//    dac_sync       : active-low frame strobe shared by both DACs
//    dac_sclk       : serial clock, idles high, DAC samples on falling edge
//    dac_din_a/b    : serial data lines, one per DAC
//    busy           : transmitter is not idle
//    frames_sent    : wrapping count of completed frames
module audio_dac_tx
   import audio_dac_pkg::*;
#(
   parameter int HALF_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_valid,
   input  logic [11:0] sample_a,
   input  logic [11:0] sample_b,
   output logic        sample_ready,
   output logic        dac_sync,
   output logic        dac_sclk,
   output logic        dac_din_a,
   output logic        dac_din_b,
   output logic        busy,
   output logic [15:0] frames_sent
);

   localparam logic [3:0] TOP_BIT  = 4'(FRAME_BITS - 1);
   localparam logic [3:0] GAP_LAST = 4'(GAP_HALVES - 1);

   dac_state_t             state, state_n;
   logic                   hold_full, hold_full_n;
   logic [11:0]            hold_a, hold_a_n, hold_b, hold_b_n;
   logic [FRAME_BITS-1:0]  shift_a, shift_a_n, shift_b, shift_b_n;
   logic [3:0]             bit_idx, bit_idx_n;
   logic                   high_half, high_half_n;
   logic                   sync_n, sclk_n;
   logic [15:0]            frames_n;
   logic                   tick, accept, start;

   dac_half_tick #(.HALF_DIV(HALF_DIV)) u_half_tick (
      .clk   (clk),
      .reset (reset),
      .run   (state != ST_IDLE),
      .tick  (tick)
   );

   assign sample_ready = !hold_full;
   assign busy         = (state != ST_IDLE);
   assign dac_din_a    = shift_a[FRAME_BITS-1];
   assign dac_din_b    = shift_b[FRAME_BITS-1];

   // Next-state and next-output logic. Every serial output is computed here
   // and registered below, so the pins never glitch. Data moves only on the
   // half-tick where SCLK rises, which keeps DIN stable across each falling
   // edge the DAC samples on. In GAP, bit_idx is reused to count half-periods.
   always_comb begin
      state_n     = state;
      hold_full_n = hold_full;
      hold_a_n    = hold_a;
      hold_b_n    = hold_b;
      shift_a_n   = shift_a;
      shift_b_n   = shift_b;
      bit_idx_n   = bit_idx;
      high_half_n = high_half;
      sync_n      = dac_sync;
      sclk_n      = dac_sclk;
      frames_n    = frames_sent;
      accept      = sample_valid && !hold_full;
      start       = 1'b0;

      case (state)
         ST_IDLE: begin
            start = hold_full;
         end
         ST_SETUP: begin
            if (tick) begin
               state_n     = ST_SHIFT;
               sclk_n      = 1'b0;
               high_half_n = 1'b0;
               bit_idx_n   = TOP_BIT;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               if (!high_half) begin
                  sclk_n      = 1'b1;
                  high_half_n = 1'b1;
                  if (bit_idx != 4'd0) begin
                     shift_a_n = shift_a << 1;
                     shift_b_n = shift_b << 1;
                  end
               end else if (bit_idx == 4'd0) begin
                  state_n   = ST_GAP;
                  sync_n    = 1'b1;
                  shift_a_n = '0;
                  shift_b_n = '0;
                  frames_n  = frames_sent + 16'd1;
                  bit_idx_n = 4'd0;
               end else begin
                  sclk_n      = 1'b0;
                  high_half_n = 1'b0;
                  bit_idx_n   = bit_idx - 4'd1;
               end
            end
         end
         ST_GAP: begin
            if (tick) begin
               if (bit_idx == GAP_LAST) begin
                  if (hold_full) begin
                     start = 1'b1;
                  end else begin
                     state_n = ST_IDLE;
                  end
               end else begin
                  bit_idx_n = bit_idx + 4'd1;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      if (start) begin
         state_n     = ST_SETUP;
         sync_n      = 1'b0;
         sclk_n      = 1'b1;
         high_half_n = 1'b0;
         bit_idx_n   = TOP_BIT;
         shift_a_n   = make_frame(hold_a);
         shift_b_n   = make_frame(hold_b);
      end

      // Loading empties the holding register unless a new pair lands on the
      // same edge; the holding register never changes while it is full.
      hold_full_n = accept || (hold_full && !start);
      if (accept) begin
         hold_a_n = sample_a;
         hold_b_n = sample_b;
      end
   end

   // State and output registers. Reset wins over any simultaneous transfer
   // and abandons a partially sent frame with the lines parked idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         hold_full   <= 1'b0;
         hold_a      <= '0;
         hold_b      <= '0;
         shift_a     <= '0;
         shift_b     <= '0;
         bit_idx     <= '0;
         high_half   <= 1'b0;
         dac_sync    <= 1'b1;
         dac_sclk    <= 1'b1;
         frames_sent <= '0;
      end else begin
         state       <= state_n;
         hold_full   <= hold_full_n;
         hold_a      <= hold_a_n;
         hold_b      <= hold_b_n;
         shift_a     <= shift_a_n;
         shift_b     <= shift_b_n;
         bit_idx     <= bit_idx_n;
         high_half   <= high_half_n;
         dac_sync    <= sync_n;
         dac_sclk    <= sclk_n;
         frames_sent <= frames_n;
      end
   end

endmodule
